// File: rtl/ycell_pkg.sv
// Shared dual-rail token encoding and helpers for the Y-cell matching element.
package ycell_pkg;

  localparam logic [1:0] V_EMPTY = 2'b00;
  localparam logic [1:0] V_ZERO  = 2'b01;
  localparam logic [1:0] V_ONE   = 2'b10;

  // A token carries data only when exactly one rail is high; 2'b11 never counts.
  function automatic logic is_valid(input logic [1:0] token);
    return (token == V_ZERO) || (token == V_ONE);
  endfunction

  // Dual-rail AND: empty unless both operands hold a legal value.
  function automatic logic [1:0] dr_and(input logic [1:0] a, input logic [1:0] b);
    logic [1:0] r;
    if (!is_valid(a) || !is_valid(b)) begin
      r = V_EMPTY;
    end else if ((a == V_ONE) && (b == V_ONE)) begin
      r = V_ONE;
    end else begin
      r = V_ZERO;
    end
    return r;
  endfunction

endpackage

// File: rtl/yc_rail_latch.sv
// Two-bit dual-rail token latch: captures a legal token only while empty,
// holds it until a synchronous clear, and resets asynchronously to empty.
module yc_rail_latch
  import ycell_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic [1:0] d,
  output logic [1:0] q
);

  // Capture-when-empty register; clear wins over capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= V_EMPTY;
    end else if (clr) begin
      q <= V_EMPTY;
    end else if ((q == V_EMPTY) && is_valid(d)) begin
      q <= d;
    end
  end

endmodule

// File: rtl/ycell_fsm.sv
// Morphle Logic Y-cell matching element: latches the data and match tokens,
// emits their dual-rail AND, and empties once both inputs return to empty.
module ycell_fsm
  import ycell_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] in,
  input  logic [1:0] match,
  output logic [1:0] out
);

  logic       clear;
  logic [1:0] lin;
  logic [1:0] lmatch;

  // Return-to-zero: the cell empties only when both inputs are empty together.
  always_comb begin
    clear = (in == V_EMPTY) && (match == V_EMPTY);
  end

  yc_rail_latch u_lin (
    .clk   (clk),
    .reset (reset),
    .clr   (clear),
    .d     (in),
    .q     (lin)
  );

  yc_rail_latch u_lmatch (
    .clk   (clk),
    .reset (reset),
    .clr   (clear),
    .d     (match),
    .q     (lmatch)
  );

  // Output depends on the latched tokens only, so input glitches never reach out.
  always_comb begin
    out = dr_and(lin, lmatch);
  end

endmodule

// File: tb/tb_ycell_fsm.sv
// Scoreboard bench for ycell_fsm: each step drives inputs, queues the
// expected output for the next edge, and compares it just after that edge.
module tb_ycell_fsm;

  logic       clk;
  logic       reset;
  logic [1:0] in;
  logic [1:0] match;
  logic [1:0] out;

  int total = 0;
  int bad   = 0;

  logic [1:0] exp_q[$];

  ycell_fsm dut (
    .clk   (clk),
    .reset (reset),
    .in    (in),
    .match (match),
    .out   (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [1:0] got, input logic [1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: out=%b expected=%b at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Drive one input pair, queue the expected result, check one edge later.
  task automatic step(input string tag, input logic [1:0] i, input logic [1:0] m,
                      input logic [1:0] e);
    logic [1:0] want;
    in    = i;
    match = m;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    want = exp_q.pop_front();
    chk(tag, out, want);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not end, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    in    = 2'b00;
    match = 2'b00;
    #12;
    chk("reset_low", out, 2'b00);
    @(negedge clk);
    reset = 1'b1;

    // idle after reset
    step("idle0", 2'b00, 2'b00, 2'b00);
    step("idle1", 2'b00, 2'b00, 2'b00);
    step("idle2", 2'b00, 2'b00, 2'b00);

    // 1 AND 1 then teardown
    step("and11_in",     2'b10, 2'b00, 2'b00);
    step("and11_match",  2'b10, 2'b10, 2'b10);
    step("and11_mdrop",  2'b10, 2'b00, 2'b10);
    step("and11_clear",  2'b00, 2'b00, 2'b00);

    // match-only token never produces output and is cleared
    step("monly_set",    2'b00, 2'b01, 2'b00);
    step("monly_clear",  2'b00, 2'b00, 2'b00);
    // lmatch must really have cleared: fresh V1/V0 pair yields V0
    step("monly_in",     2'b10, 2'b00, 2'b00);
    step("and10",        2'b10, 2'b01, 2'b01);
    step("and10_clear",  2'b00, 2'b00, 2'b00);

    // ignore input changes while latched
    step("ign_set",      2'b10, 2'b10, 2'b10);
    step("ign_idrop",    2'b00, 2'b10, 2'b10);
    step("ign_swap",     2'b01, 2'b10, 2'b10);
    step("ign_mdrop",    2'b01, 2'b00, 2'b10);
    step("ign_clear",    2'b00, 2'b00, 2'b00);

    // zero result, both on the same edge
    step("and01_same",   2'b01, 2'b10, 2'b01);
    step("and01_clear",  2'b00, 2'b00, 2'b00);
    step("and10_same",   2'b10, 2'b01, 2'b01);
    step("and10s_clear", 2'b00, 2'b00, 2'b00);

    // illegal 2'b11 on in is never captured
    step("ill_alone",    2'b11, 2'b00, 2'b00);
    step("ill_match",    2'b11, 2'b10, 2'b00);
    step("ill_gap",      2'b00, 2'b10, 2'b00);
    step("ill_legal",    2'b01, 2'b10, 2'b01);
    step("ill_clear",    2'b00, 2'b00, 2'b00);

    // async reset between edges
    step("ar_set",       2'b10, 2'b10, 2'b10);
    #2;
    reset = 1'b0;
    #1;
    chk("ar_immediate", out, 2'b00);
    step("ar_held",      2'b10, 2'b10, 2'b00);
    step("ar_held2",     2'b10, 2'b10, 2'b00);
    @(negedge clk);
    reset = 1'b1;
    step("ar_recap",     2'b10, 2'b10, 2'b10);
    step("ar_clear",     2'b00, 2'b00, 2'b00);

    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: left=%0d expected=0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
